// File: rtl/mem_rd_pkg.sv
// Shared types and constants for the load read port.
package mem_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 2;
    localparam int BYTE_W     = 8;

    function automatic int cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects and extends the loaded byte, or passes the full word through.
module load_extend
    import mem_rd_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] rdata_i,
    input  logic         lsb_i,
    input  logic         byte_i,
    input  logic         signed_i,
    output logic [N-1:0] data_o
);

    logic [BYTE_W-1:0] b;
    logic              ext;

    always_comb begin
        b      = lsb_i ? rdata_i[WORD_BYTES*BYTE_W-1:BYTE_W]
                       : rdata_i[BYTE_W-1:0];
        ext    = signed_i & b[BYTE_W-1];
        data_o = rdata_i;
        if (byte_i) begin
            data_o = {{(N-BYTE_W){ext}}, b};
        end
    end

endmodule

// File: rtl/mem_read_port.sv
// Load port: issues one memory read, waits LATENCY cycles,
// formats the returned word and holds it until the core accepts it.
module mem_read_port
    import mem_rd_pkg::*;
#(
    parameter int N       = 16,
    parameter int A       = 16,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [A-1:0] req_addr,
    input  logic         req_byte,
    input  logic         req_signed,
    output logic         mem_re,
    output logic [A-1:0] mem_addr,
    input  logic [N-1:0] mem_rdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_err,
    output logic         busy
);

    localparam int CW = cnt_width(LATENCY);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            lsb_q;
    logic            byte_q;
    logic            sgn_q;
    logic            mem_re_q;
    logic [A-1:0]    mem_addr_q;
    logic            rsp_valid_q;
    logic [N-1:0]    rsp_data_q;
    logic            rsp_err_q;
    logic [N-1:0]    fmt_d;

    load_extend #(.N(N)) u_ext (
        .rdata_i  (mem_rdata),
        .lsb_i    (lsb_q),
        .byte_i   (byte_q),
        .signed_i (sgn_q),
        .data_o   (fmt_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lsb_q       <= 1'b0;
            byte_q      <= 1'b0;
            sgn_q       <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            mem_re_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        lsb_q  <= req_addr[0];
                        byte_q <= req_byte;
                        sgn_q  <= req_signed;
                        // misaligned word: answer with an error, no access
                        if (!req_byte && req_addr[0]) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end else begin
                            state_q    <= WAIT;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= {req_addr[A-1:1], 1'b0};
                            cnt_q      <= CW'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= fmt_d;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_read_port.sv
// Bench: three lanes (LATENCY 2, 1, 4) checked every cycle
// against a transaction-level model, plus directed literal checks.
module tb_mem_read_port;

    localparam int NL = 3;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic        reset;
    logic        req_valid [NL];
    logic [15:0] req_addr  [NL];
    logic        req_byte  [NL];
    logic        req_signed[NL];
    logic        rsp_ready [NL];
    logic [15:0] mem_rdata [NL];

    logic        req_ready [NL];
    logic        mem_re    [NL];
    logic [15:0] mem_addr  [NL];
    logic        rsp_valid [NL];
    logic [15:0] rsp_data  [NL];
    logic        rsp_err   [NL];
    logic        busy      [NL];

    for (genvar g = 0; g < NL; g++) begin : lane
        mem_read_port #(
            .N       (16),
            .A       (16),
            .LATENCY ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_addr   (req_addr[g]),
            .req_byte   (req_byte[g]),
            .req_signed (req_signed[g]),
            .mem_re     (mem_re[g]),
            .mem_addr   (mem_addr[g]),
            .mem_rdata  (mem_rdata[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_data   (rsp_data[g]),
            .rsp_err    (rsp_err[g]),
            .busy       (busy[g])
        );
    end

    int checks = 0;
    int errors = 0;

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    endfunction

    // memory contents: fixed hash of the address unless overridden
    bit          ovr_en [NL];
    logic [15:0] ovr_val[NL];
    bit          junk_en;
    logic [15:0] junk_val;

    function automatic logic [15:0] memf(input int g, input logic [15:0] wa);
        if (ovr_en[g]) return ovr_val[g];
        return 16'(wa * 16'd40503) ^ 16'h3C5A;
    endfunction

    function automatic logic [15:0] fmt(input logic [15:0] w, input logic a0,
                                        input logic by, input logic sg);
        int b;
        if (!by) return w;
        b = a0 ? int'(w) / 256 : int'(w) % 256;
        if (sg && b >= 128) b = b + 65280;
        return 16'(b);
    endfunction

    task automatic chk(input string nm, input int g,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s lane%0d got=%h want=%h t=%0t",
                         nm, g, act, exp, $time);
        end
    endtask

    // transaction model, advanced on each posedge from the driven inputs
    int          k = 0;
    bit          pend   [NL];
    int          t_acc  [NL];
    int          t_rsp  [NL];
    logic [15:0] e_data [NL];
    logic [15:0] e_addr [NL];
    bit          e_err  [NL];
    bit          was_rst[NL];
    int          n_rsp  [NL];

    initial forever begin
        @(posedge clk);
        k++;
        for (int g = 0; g < NL; g++) begin
            if (!reset) begin
                pend[g]    = 1'b0;
                e_addr[g]  = 16'h0;
                was_rst[g] = 1'b1;
            end else begin
                was_rst[g] = 1'b0;
                if (pend[g]) begin
                    if (k > t_rsp[g] && rsp_ready[g]) pend[g] = 1'b0;
                end else if (req_valid[g]) begin
                    pend[g]  = 1'b1;
                    t_acc[g] = k;
                    e_err[g] = !req_byte[g] && req_addr[g][0];
                    if (e_err[g]) begin
                        t_rsp[g]  = k;
                        e_data[g] = 16'h0;
                    end else begin
                        e_addr[g] = {req_addr[g][15:1], 1'b0};
                        t_rsp[g]  = k + lat_of(g) + 1;
                        e_data[g] = fmt(memf(g, e_addr[g]), req_addr[g][0],
                                        req_byte[g], req_signed[g]);
                    end
                end
            end
        end
    end

    // synchronous memory: data valid only in the LATENCY-th cycle after mem_re
    int          age[NL];
    logic [15:0] ma [NL];

    initial begin
        for (int g = 0; g < NL; g++) begin
            age[g] = -1;
            ma[g] = 16'h0;
            mem_rdata[g] = 16'h0;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int g = 0; g < NL; g++) begin
                if (mem_re[g]) begin
                    age[g] = 0;
                    ma[g] = mem_addr[g];
                end else if (age[g] >= 0 && age[g] < 100) begin
                    age[g]++;
                end
                if (age[g] == lat_of(g)) mem_rdata[g] = memf(g, ma[g]);
                else if (junk_en) mem_rdata[g] = junk_val;
                else mem_rdata[g] = 16'($urandom);
            end
        end
    end

    // single compare process
    initial forever begin
        @(negedge clk);
        if (k > 0) begin
            for (int g = 0; g < NL; g++) begin
                chk("req_ready", g, req_ready[g], !pend[g]);
                chk("busy", g, busy[g], pend[g]);
                chk("mem_re", g, mem_re[g],
                    pend[g] && !e_err[g] && k == t_acc[g]);
                if (was_rst[g]) begin
                    chk("rst_mem_addr", g, mem_addr[g], 16'h0);
                    chk("rst_rsp_data", g, rsp_data[g], 16'h0);
                    chk("rst_rsp_err", g, rsp_err[g], 1'b0);
                end else if (pend[g] && !e_err[g] && k < t_rsp[g]) begin
                    chk("mem_addr", g, mem_addr[g], e_addr[g]);
                end
                chk("rsp_valid", g, rsp_valid[g], pend[g] && k >= t_rsp[g]);
                if (pend[g] && k >= t_rsp[g]) begin
                    chk("rsp_data", g, rsp_data[g], e_data[g]);
                    chk("rsp_err", g, rsp_err[g], e_err[g]);
                    if (rsp_ready[g]) n_rsp[g]++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        for (int g = 0; g < NL; g++) begin
            req_valid[g]  = 1'b0;
            req_addr[g]   = 16'h0;
            req_byte[g]   = 1'b0;
            req_signed[g] = 1'b0;
            rsp_ready[g]  = (g != 0);
        end
    endtask

    task automatic wait_rsp(input int g, output int lat);
        lat = 0;
        while (!rsp_valid[g] && lat < 20) begin
            tick();
            lat++;
        end
        if (!rsp_valid[g]) chk("rsp_timeout", g, 32'd0, 32'd1);
    endtask

    task automatic load0(input logic [15:0] a, input logic by,
                         input logic sg, output int lat);
        req_valid[0]  = 1'b1;
        req_addr[0]   = a;
        req_byte[0]   = by;
        req_signed[0] = sg;
        tick();
        req_valid[0] = 1'b0;
        wait_rsp(0, lat);
    endtask

    task automatic take0;
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready[0] = 1'b0;
    endtask

    logic [15:0] b_addr[4] = '{16'h0041, 16'h0041, 16'h0040, 16'h0040};
    logic        b_sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] b_exp [4] = '{16'hFF80, 16'h0080, 16'hFFF7, 16'h00F7};
    int          l_exp [NL] = '{3, 2, 5};

    initial begin
        int lat;
        int seen;
        reset = 1'b0;
        junk_en = 1'b0;
        junk_val = 16'h0;
        for (int g = 0; g < NL; g++) begin
            ovr_en[g] = 1'b0;
            ovr_val[g] = 16'h0;
        end
        idle_inputs();
        repeat (3) tick();
        chk("reset_rsp_valid", 0, rsp_valid[0], 1'b0);
        chk("reset_req_ready", 0, req_ready[0], 1'b1);
        reset = 1'b1;
        tick();

        // word load
        ovr_en[0] = 1'b1;
        ovr_val[0] = 16'hBEEF;
        req_valid[0] = 1'b1;
        req_addr[0] = 16'h0040;
        tick();
        req_valid[0] = 1'b0;
        chk("word_mem_re", 0, mem_re[0], 1'b1);
        chk("word_mem_addr", 0, mem_addr[0], 16'h0040);
        wait_rsp(0, lat);
        chk("word_latency", 0, lat, l_exp[0]);
        chk("word_data", 0, rsp_data[0], 16'hBEEF);
        chk("word_err", 0, rsp_err[0], 1'b0);
        take0();

        // byte loads
        ovr_val[0] = 16'h80F7;
        for (int i = 0; i < 4; i++) begin
            load0(b_addr[i], 1'b1, b_sg[i], lat);
            chk("byte_data", 0, rsp_data[0], b_exp[i]);
            chk("byte_latency", 0, lat, 3);
            take0();
        end

        // misaligned word
        load0(16'h0043, 1'b0, 1'b0, lat);
        chk("mis_latency", 0, lat, 0);
        chk("mis_err", 0, rsp_err[0], 1'b1);
        chk("mis_data", 0, rsp_data[0], 16'h0000);
        take0();

        // backpressure
        load0(16'h0040, 1'b0, 1'b0, lat);
        junk_en = 1'b1;
        junk_val = 16'h1234;
        req_valid[0] = 1'b1;
        req_addr[0] = 16'h0100;
        repeat (5) begin
            tick();
            chk("bp_data", 0, rsp_data[0], 16'h80F7);
            chk("bp_req_ready", 0, req_ready[0], 1'b0);
        end
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready[0] = 1'b0;
        chk("bp_idle", 0, req_ready[0], 1'b1);
        tick();
        req_valid[0] = 1'b0;
        junk_en = 1'b0;
        chk("bp_accept", 0, mem_re[0], 1'b1);
        chk("bp_new_addr", 0, mem_addr[0], 16'h0100);
        wait_rsp(0, lat);
        take0();

        // reset in the middle of WAIT
        ovr_val[0] = 16'hAAAA;
        req_valid[0] = 1'b1;
        req_addr[0] = 16'h0040;
        tick();
        req_valid[0] = 1'b0;
        chk("rw_mem_re", 0, mem_re[0], 1'b1);
        tick();
        reset = 1'b0;
        tick();
        chk("rw_mem_re0", 0, mem_re[0], 1'b0);
        chk("rw_mem_addr", 0, mem_addr[0], 16'h0);
        chk("rw_rsp_data", 0, rsp_data[0], 16'h0);
        chk("rw_busy", 0, busy[0], 1'b0);
        reset = 1'b1;
        seen = 0;
        repeat (6) begin
            tick();
            if (rsp_valid[0]) seen++;
        end
        chk("rw_no_rsp", 0, seen, 0);
        ovr_en[0] = 1'b0;

        // latency of the other lanes
        for (int g = 1; g < NL; g++) begin
            req_valid[g] = 1'b1;
            req_addr[g] = 16'h0040;
            tick();
            req_valid[g] = 1'b0;
            wait_rsp(g, lat);
            chk("lane_latency", g, lat, l_exp[g]);
            tick();
        end

        // randomized traffic on all lanes
        repeat (3000) begin
            for (int g = 0; g < NL; g++) begin
                req_valid[g]  = (g == 0) ? ($urandom % 4 != 0) : 1'b1;
                req_addr[g]   = 16'($urandom);
                req_byte[g]   = 1'($urandom);
                req_signed[g] = 1'($urandom);
                rsp_ready[g]  = (g == 0) ? 1'($urandom) : 1'b1;
            end
            reset = ($urandom % 250 != 0);
            tick();
        end
        idle_inputs();
        rsp_ready[0] = 1'b1;
        reset = 1'b1;
        repeat (10) tick();
        for (int g = 0; g < NL; g++) chk("traffic", g, n_rsp[g] > 50, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
